nt_node_activation_monitor: RTL and testbench

//  Downstream observer for an Nt-node subcircuit output (e.g. a test_I5xxx

---
 rtl/nt_node_activation_monitor.sv | 178 +++++++++++++++++
 tb/tb_nt_node_activation_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nt_node_activation_monitor.sv
// Per-window activity observer for a single-bit subcircuit net: counts ones and
// toggles, flags long runs of ones and rare activity, reports once per window.
module nt_node_activation_monitor #(
   parameter int WINDOW      = 256,
   parameter int CNT_W       = 16,
   parameter int TRIG_RUN    = 4,
   parameter int RARE_THRESH = 2
) (
   input  logic             I1470_clk,
   input  logic             I1477_rst,
   input  logic             enable,
   input  logic             node_in,
   input  logic             sample_en,
   output logic             rep_valid,
   input  logic             rep_ready,
   output logic [CNT_W-1:0] rep_ones,
   output logic [CNT_W-1:0] rep_toggles,
   output logic             rep_trig,
   output logic             rep_rare,
   output logic             overrun
);

   localparam int RUN_W = (TRIG_RUN < 2) ? 1 : $clog2(TRIG_RUN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] RARE_LIM  = CNT_W'(RARE_THRESH);
   localparam logic [RUN_W-1:0] RUN_TOP   = RUN_W'(TRIG_RUN);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic             w_accept;
   logic             w_close;
   logic             w_discard;
   logic             w_load;
   logic             w_drop;

   logic [CNT_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_ones;
   logic [CNT_W-1:0] r_toggles;
   logic             r_trig_acc;
   logic             r_prev_sample;
   logic [RUN_W-1:0] r_run;

   logic [CNT_W-1:0] w_win_next;
   logic [CNT_W-1:0] w_ones_next;
   logic [CNT_W-1:0] w_toggles_next;
   logic [RUN_W-1:0] w_run_next;
   logic             w_trig_next;

   logic             r_rep_valid;
   logic [CNT_W-1:0] r_rep_ones;
   logic [CNT_W-1:0] r_rep_toggles;
   logic             r_rep_trig;
   logic             r_rep_rare;
   logic             r_overrun;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic inc);
      sat_inc = (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
   endfunction

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_discard    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (!enable) begin
               w_state_next = ST_IDLE;
               w_discard    = 1'b1;
            end else if (sample_en) begin
               w_accept = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Window statistics including the sample being accepted this cycle, so the
   // closing sample lands in the report.
   always_comb begin
      w_win_next     = sat_inc(r_win_cnt, 1'b1);
      w_ones_next    = sat_inc(r_ones, node_in);
      w_toggles_next = sat_inc(r_toggles, node_in ^ r_prev_sample);
      if (!node_in) begin
         w_run_next = '0;
      end else if (r_run == RUN_TOP) begin
         w_run_next = r_run;
      end else begin
         w_run_next = r_run + RUN_W'(1);
      end
      w_trig_next = r_trig_acc | (w_run_next == RUN_TOP);
   end

   assign w_close = w_accept && (r_win_cnt == WIN_LAST);
   assign w_drop  = w_close && r_rep_valid && !rep_ready;
   assign w_load  = w_close && !w_drop;

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         r_win_cnt     <= '0;
         r_ones        <= '0;
         r_toggles     <= '0;
         r_trig_acc    <= 1'b0;
         r_prev_sample <= 1'b0;
         r_run         <= '0;
      end else begin
         // Run length and last value span window boundaries and disables.
         if (w_accept) begin
            r_prev_sample <= node_in;
            r_run         <= w_run_next;
         end
         if (w_discard || w_close) begin
            r_win_cnt  <= '0;
            r_ones     <= '0;
            r_toggles  <= '0;
            r_trig_acc <= 1'b0;
         end else if (w_accept) begin
            r_win_cnt  <= w_win_next;
            r_ones     <= w_ones_next;
            r_toggles  <= w_toggles_next;
            r_trig_acc <= w_trig_next;
         end
      end
   end

   // A close while the consumer stalls keeps the older report and flags it.
   always_ff @(posedge I1470_clk) begin
      if (I1477_rst) begin
         r_rep_valid   <= 1'b0;
         r_rep_ones    <= '0;
         r_rep_toggles <= '0;
         r_rep_trig    <= 1'b0;
         r_rep_rare    <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         if (w_load) begin
            r_rep_valid   <= 1'b1;
            r_rep_ones    <= w_ones_next;
            r_rep_toggles <= w_toggles_next;
            r_rep_trig    <= w_trig_next;
            r_rep_rare    <= (w_ones_next <= RARE_LIM);
         end else if (r_rep_valid && rep_ready) begin
            r_rep_valid <= 1'b0;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign rep_valid   = r_rep_valid;
   assign rep_ones    = r_rep_ones;
   assign rep_toggles = r_rep_toggles;
   assign rep_trig    = r_rep_trig;
   assign rep_rare    = r_rep_rare;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_nt_node_activation_monitor.sv
// Bench for nt_node_activation_monitor (WINDOW=8): table of windows with
// hand-derived reports fed to a scoreboard queue, plus stall/reset/disable sequences.
module tb_nt_node_activation_monitor;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic             node_in = 1'b0;
   logic             sample_en = 1'b0;
   logic             rep_ready = 1'b0;
   logic             rep_valid;
   logic [CNT_W-1:0] rep_ones;
   logic [CNT_W-1:0] rep_toggles;
   logic             rep_trig;
   logic             rep_rare;
   logic             overrun;

   typedef struct {
      logic [7:0]       bits;   // bits[7] is the first sample
      bit               gap;    // idle cycle after each qualified sample
      logic [CNT_W-1:0] ones;
      logic [CNT_W-1:0] tog;
      logic             trig;
      logic             rare;
   } vec_t;

   vec_t tbl[6];
   vec_t q[$];
   vec_t mon_e;
   vec_t w_a, w_b, w_c, w_d, w_f, w_g;
   int   checks = 0;
   int   errors = 0;

   nt_node_activation_monitor #(
      .WINDOW(8), .CNT_W(CNT_W), .TRIG_RUN(4), .RARE_THRESH(2)
   ) dut (
      .I1470_clk  (clk),
      .I1477_rst  (rst),
      .enable     (enable),
      .node_in    (node_in),
      .sample_en  (sample_en),
      .rep_valid  (rep_valid),
      .rep_ready  (rep_ready),
      .rep_ones   (rep_ones),
      .rep_toggles(rep_toggles),
      .rep_trig   (rep_trig),
      .rep_rare   (rep_rare),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},   32'(rep_valid),   32'd0);
      chk({tag, "_ones"},    32'(rep_ones),    32'd0);
      chk({tag, "_toggles"}, 32'(rep_toggles), 32'd0);
      chk({tag, "_trig"},    32'(rep_trig),    32'd0);
      chk({tag, "_rare"},    32'(rep_rare),    32'd0);
      chk({tag, "_overrun"}, 32'(overrun),     32'd0);
   endtask

   // Drives one 8-sample window; the expected report is queued as the closing
   // sample is driven.
   task automatic run_window(input vec_t v, input bit push, input bit pre_valid,
                             input bit ready_last);
      for (int i = 0; i < 8; i++) begin
         node_in   = v.bits[7-i];
         sample_en = 1'b1;
         if (i == 7) begin
            chk("pre_close_valid", 32'(rep_valid), 32'(pre_valid));
            if (push) q.push_back(v);
            if (ready_last) rep_ready = 1'b1;
         end
         step();
         if (v.gap && i != 7) begin
            sample_en = 1'b0;
            node_in   = ~node_in;
            step();
         end
      end
      sample_en = 1'b0;
      chk("post_close_valid", 32'(rep_valid), 32'd1);
      $display("window bits=%b gap=%0d ones=%0d tog=%0d trig=%0d rare=%0d valid=%0d ovr=%0d",
               v.bits, v.gap, rep_ones, rep_toggles, rep_trig, rep_rare, rep_valid, overrun);
   endtask

   initial begin
      tbl[0] = '{8'b10101010, 1'b0, 16'd4, 16'd8, 1'b0, 1'b0};
      tbl[1] = '{8'b01111000, 1'b0, 16'd4, 16'd2, 1'b1, 1'b0};
      tbl[2] = '{8'b00000000, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1};
      tbl[3] = '{8'b11111111, 1'b0, 16'd8, 16'd1, 1'b1, 1'b0};
      tbl[4] = '{8'b01100001, 1'b1, 16'd3, 16'd4, 1'b0, 1'b0};
      tbl[5] = '{8'b10100000, 1'b0, 16'd2, 16'd3, 1'b0, 1'b1};
      w_a    = '{8'b11110000, 1'b0, 16'd4, 16'd2, 1'b1, 1'b0};
      w_b    = '{8'b00000000, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1};
      w_c    = '{8'b10101010, 1'b0, 16'd4, 16'd8, 1'b0, 1'b0};
      w_d    = '{8'b01111000, 1'b0, 16'd4, 16'd2, 1'b1, 1'b0};
      w_f    = '{8'b11100000, 1'b0, 16'd3, 16'd2, 1'b0, 1'b0};
      w_g    = '{8'b10000000, 1'b0, 16'd1, 16'd1, 1'b1, 1'b1};

      fork
         forever begin
            @(negedge clk);
            if (rep_valid === 1'b1 && rep_ready === 1'b1) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_report actual=ones %0d required=none t=%0t",
                           rep_ones, $time);
               end else begin
                  mon_e = q.pop_front();
                  $display("report ones=%0d tog=%0d trig=%0d rare=%0d (want %0d %0d %0d %0d)",
                           rep_ones, rep_toggles, rep_trig, rep_rare,
                           mon_e.ones, mon_e.tog, mon_e.trig, mon_e.rare);
                  chk("sb_ones",    32'(rep_ones),    32'(mon_e.ones));
                  chk("sb_toggles", 32'(rep_toggles), 32'(mon_e.tog));
                  chk("sb_trig",    32'(rep_trig),    32'(mon_e.trig));
                  chk("sb_rare",    32'(rep_rare),    32'(mon_e.rare));
               end
            end
         end
      join_none

      // Reset state
      repeat (3) step();
      chk_all_zero("reset");
      rst       = 1'b0;
      enable    = 1'b1;
      rep_ready = 1'b1;
      step();

      // Table windows with a ready consumer
      for (int t = 0; t < 6; t++) begin
         run_window(tbl[t], 1'b1, 1'b0, 1'b0);
      end
      step();

      // Stalled consumer across two windows: second report dropped
      rep_ready = 1'b0;
      run_window(w_a, 1'b1, 1'b0, 1'b0);
      chk("overrun_before", 32'(overrun), 32'd0);
      run_window(w_b, 1'b0, 1'b1, 1'b0);
      chk("held_ones",    32'(rep_ones),    32'd4);
      chk("held_toggles", 32'(rep_toggles), 32'd2);
      chk("held_trig",    32'(rep_trig),    32'd1);
      chk("held_rare",    32'(rep_rare),    32'd0);
      chk("overrun_set",  32'(overrun),     32'd1);
      rep_ready = 1'b1;
      step();
      chk("valid_drop_after_accept", 32'(rep_valid), 32'd0);

      // Accept on the closing edge: new report loads, valid stays high
      rep_ready = 1'b0;
      run_window(w_c, 1'b1, 1'b0, 1'b0);
      run_window(w_d, 1'b1, 1'b1, 1'b1);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      step();
      chk("valid_low_after_d", 32'(rep_valid), 32'd0);

      // Reset in the middle of a window
      for (int i = 0; i < 4; i++) begin
         node_in   = 1'b1;
         sample_en = 1'b1;
         step();
      end
      rst = 1'b1;
      step();
      chk_all_zero("midreset");
      rst       = 1'b0;
      sample_en = 1'b0;
      step();
      run_window(w_f, 1'b1, 1'b0, 1'b0);
      step();

      // Disable mid-window: partial counts discarded, run/prev kept
      for (int i = 0; i < 4; i++) begin
         node_in   = (i != 0);
         sample_en = 1'b1;
         step();
      end
      enable  = 1'b0;
      node_in = 1'b1;
      step();
      enable    = 1'b1;
      sample_en = 1'b0;
      step();
      run_window(w_g, 1'b1, 1'b0, 1'b0);
      step();
      step();

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
